labs_energy: RTL and testbench

LABS_ENERGY -- requirements
Module: labs_energy

---
 rtl/labs_pkg.sv | 15 +
 rtl/labs_energy_if.sv | 24 ++
 rtl/labs_autocorr.sv | 22 ++
 rtl/labs_energy.sv | 118 +++++++++++
 tb/tb_labs_energy.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/labs_pkg.sv
// Shared types and helpers for the LABS sidelobe-energy engine.
package labs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CORR = 2'd1,
    DONE = 2'd2
  } labs_state_t;

  // Largest value representable on an e_width-bit energy output.
  function automatic logic [63:0] sat_limit(input int e_width);
    return (64'd1 << e_width) - 64'd1;
  endfunction

endpackage

// File: rtl/labs_energy_if.sv
// Sequence-in / energy-out handshake bundle for labs_energy.
interface labs_energy_if #(
  parameter int SEQ_WIDTH = 8,
  parameter int E_WIDTH   = 16
);

  logic [SEQ_WIDTH-1:0] i_seq;
  logic                 i_valid;
  logic                 o_ready;
  logic [E_WIDTH-1:0]   o_e;
  logic                 o_valid;
  logic                 i_ready;

  modport slave (
    input  i_seq, i_valid, i_ready,
    output o_ready, o_e, o_valid
  );

  modport master (
    output i_seq, i_valid, i_ready,
    input  o_ready, o_e, o_valid
  );

endinterface

// File: rtl/labs_autocorr.sv
// Aperiodic autocorrelation C_k of a +/-1 sequence at lag k, purely combinational.
module labs_autocorr #(
  parameter int SEQ_WIDTH = 8
) (
  input  logic [SEQ_WIDTH-1:0]          seq_i,
  input  logic [$clog2(SEQ_WIDTH):0]    k_i,
  output logic signed [$clog2(SEQ_WIDTH):0] c_o
);

  localparam int CW = $clog2(SEQ_WIDTH) + 1;

  logic [SEQ_WIDTH-1:0] pair_mask;
  logic [SEQ_WIDTH-1:0] agree;

  // Bit i of (seq >> k) is s_{i+k}; the mask keeps only the N-k valid pairs.
  assign pair_mask = {SEQ_WIDTH{1'b1}} >> k_i;
  assign agree     = ~(seq_i ^ (seq_i >> k_i)) & pair_mask;

  // Each agreeing pair contributes +1, each disagreeing pair -1.
  assign c_o = CW'(2 * $countones(agree) - (SEQ_WIDTH - int'(k_i)));

endmodule

// File: rtl/labs_energy.sv
// Sequential LABS energy engine: one lag per cycle, sum of C_k^2, saturating output.
module labs_energy
  import labs_pkg::*;
#(
  parameter int SEQ_WIDTH = 8,
  parameter int E_WIDTH   = 16
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_ni,
  input  logic         i_soft_rst,
  labs_energy_if.slave bus
);

  localparam int LOG_N = $clog2(SEQ_WIDTH);
  localparam int KW    = LOG_N + 1;
  localparam int CW    = LOG_N + 1;
  localparam int SQ_W  = 2 * LOG_N + 1;
  // Sized for the all-equal sequence, the worst-case sum of squares.
  localparam int ACC_W = 3 * LOG_N + 1;
  localparam logic [KW-1:0] K_END = KW'(SEQ_WIDTH);

  labs_state_t          state_q, state_d;
  logic [SEQ_WIDTH-1:0] seq_q, seq_d;
  logic [KW-1:0]        k_q, k_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [E_WIDTH-1:0]   o_e_q, o_e_d;
  logic                 o_valid_q, o_valid_d;

  logic signed [CW-1:0] c_k;
  logic [CW-1:0]        c_mag;
  logic [SQ_W-1:0]      c_sq;
  logic                 ready;
  logic                 handshake;

  labs_autocorr #(.SEQ_WIDTH(SEQ_WIDTH)) u_autocorr (
    .seq_i (seq_q),
    .k_i   (k_q),
    .c_o   (c_k)
  );

  assign c_mag = c_k[CW-1] ? $unsigned(-c_k) : $unsigned(c_k);
  assign c_sq  = SQ_W'(c_mag) * SQ_W'(c_mag);

  assign ready       = (state_q == IDLE) && wb_rst_ni;
  assign handshake   = bus.i_valid && ready;
  assign bus.o_ready = ready;
  assign bus.o_e     = o_e_q;
  assign bus.o_valid = o_valid_q;

  always_comb begin
    // NOTE: every _d gets a hold default first so no path can infer a latch.
    state_d   = state_q;
    seq_d     = seq_q;
    k_d       = k_q;
    acc_d     = acc_q;
    o_e_d     = o_e_q;
    o_valid_d = o_valid_q;

    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          seq_d   = bus.i_seq;
          acc_d   = '0;
          k_d     = KW'(1);
          state_d = CORR;
        end
      end
      CORR: begin
        if (k_q == K_END) begin
          o_e_d     = (64'(acc_q) > sat_limit(E_WIDTH)) ? {E_WIDTH{1'b1}}
                                                        : E_WIDTH'(acc_q);
          o_valid_d = 1'b1;
          state_d   = DONE;
        end else begin
          acc_d = acc_q + ACC_W'(c_sq);
          k_d   = k_q + KW'(1);
        end
      end
      DONE: begin
        if (bus.i_ready) begin
          o_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Soft clear wins over everything, including a handshake in the same cycle.
    if (i_soft_rst) begin
      state_d   = IDLE;
      seq_d     = '0;
      k_d       = '0;
      acc_d     = '0;
      o_e_d     = '0;
      o_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q   <= IDLE;
      seq_q     <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      o_e_q     <= '0;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_q     <= seq_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      o_e_q     <= o_e_d;
      o_valid_q <= o_valid_d;
    end
  end

endmodule

// File: tb/tb_labs_energy.sv
// Directed bench for labs_energy: a 16-bit and a 7-bit (saturating) instance share stimulus.
module tb_labs_energy;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       soft_rst;
  logic [7:0] seq;
  logic       valid;
  logic       ready;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  labs_energy_if #(.SEQ_WIDTH(8), .E_WIDTH(16)) bus16 ();
  labs_energy_if #(.SEQ_WIDTH(8), .E_WIDTH(7))  bus7 ();

  assign bus16.i_seq   = seq;
  assign bus16.i_valid = valid;
  assign bus16.i_ready = ready;
  assign bus7.i_seq    = seq;
  assign bus7.i_valid  = valid;
  assign bus7.i_ready  = ready;

  labs_energy #(.SEQ_WIDTH(8), .E_WIDTH(16)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .i_soft_rst (soft_rst),
    .bus        (bus16)
  );

  labs_energy #(.SEQ_WIDTH(8), .E_WIDTH(7)) dut_sat (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .i_soft_rst (soft_rst),
    .bus        (bus7)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a sequence for exactly one handshake edge.
  task automatic send(input string tag, input logic [7:0] s);
    @(negedge clk);
    seq   = s;
    valid = 1'b1;
    check({tag, "_hs_ready"}, 32'(bus16.o_ready), 32'd1);
    tick();
    valid = 1'b0;
  endtask

  // Count edges after the handshake until o_valid is seen, bounded.
  task automatic wait_result(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!bus16.o_valid && cyc < 40);
  endtask

  task automatic accept(input string tag);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check({tag, "_acc_valid"}, 32'(bus16.o_valid), 32'd0);
    check({tag, "_acc_ready"}, 32'(bus16.o_ready), 32'd1);
  endtask

  task automatic run(input string tag, input logic [7:0] s, input int exp);
    int cyc;
    int exp7;
    send(tag, s);
    wait_result(cyc);
    exp7 = (exp > 127) ? 127 : exp;
    check({tag, "_latency"}, 32'(cyc), 32'd8);
    check({tag, "_e16"}, 32'(bus16.o_e), 32'(exp));
    check({tag, "_e7"}, 32'(bus7.o_e), 32'(exp7));
    check({tag, "_valid7"}, 32'(bus7.o_valid), 32'd1);
    check({tag, "_busy"}, 32'(bus16.o_ready), 32'd0);
    accept(tag);
  endtask

  initial begin
    int cyc;
    int vcount;

    rst_n    = 1'b0;
    soft_rst = 1'b0;
    seq      = 8'h00;
    valid    = 1'b0;
    ready    = 1'b0;

    repeat (2) tick();
    check("rst_ready", 32'(bus16.o_ready), 32'd0);
    check("rst_valid", 32'(bus16.o_valid), 32'd0);
    check("rst_e16", 32'(bus16.o_e), 32'd0);
    check("rst_e7", 32'(bus7.o_e), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rel_ready", 32'(bus16.o_ready), 32'd1);

    // Hand-computed energies for N=8.
    run("ff", 8'hFF, 140);
    run("h37", 8'h37, 16);
    run("h55", 8'h55, 140);
    run("h0f", 8'h0F, 60);
    run("h00", 8'h00, 140);

    // Result held for 20 cycles with the consumer stalled; extra i_valid ignored.
    send("hold", 8'h37);
    wait_result(cyc);
    check("hold_latency", 32'(cyc), 32'd8);
    for (int i = 0; i < 20; i++) begin
      if (i == 3) begin
        seq   = 8'hFF;
        valid = 1'b1;
      end
      if (i == 12) valid = 1'b0;
      tick();
      check("hold_valid", 32'(bus16.o_valid), 32'd1);
      check("hold_e16", 32'(bus16.o_e), 32'd16);
      check("hold_ready", 32'(bus16.o_ready), 32'd0);
    end
    accept("hold");
    run("after_hold", 8'h0F, 60);

    // Soft clear in the third CORR cycle aborts the computation.
    send("srst", 8'hFF);
    tick();
    tick();
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    check("srst_ready", 32'(bus16.o_ready), 32'd1);
    check("srst_valid", 32'(bus16.o_valid), 32'd0);
    vcount = 0;
    repeat (12) begin
      tick();
      if (bus16.o_valid) vcount++;
    end
    check("srst_no_valid", 32'(vcount), 32'd0);
    run("srst_h37", 8'h37, 16);

    // Hard reset while a result is pending.
    send("rstd", 8'h55);
    wait_result(cyc);
    check("rstd_latency", 32'(cyc), 32'd8);
    rst_n = 1'b0;
    tick();
    check("rstd_valid", 32'(bus16.o_valid), 32'd0);
    check("rstd_e16", 32'(bus16.o_e), 32'd0);
    check("rstd_e7", 32'(bus7.o_e), 32'd0);
    check("rstd_ready_low", 32'(bus16.o_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rstd_rel_ready", 32'(bus16.o_ready), 32'd1);
    check("rstd_rel_valid", 32'(bus16.o_valid), 32'd0);
    run("post_rst", 8'hFF, 140);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
